// File: rtl/instr_ram_pkg.sv
// Shared types and helpers for the banked instruction-RAM controller.
package instr_ram_pkg;

  // Controller phases: memory scrub after reset, then normal service.
  typedef enum logic {
    INIT,
    READY
  } state_e;

  // Scrub fill pattern: RV32 NOP (addi x0, x0, 0).
  localparam logic [31:0] INIT_WORD_DEFAULT = 32'h0000_0013;

  // Bank index of a word address: word-interleaved, so the low bits pick the bank.
  function automatic logic [31:0] bank_sel(input logic [31:0] wa,
                                           input int unsigned bank_bits);
    logic [31:0] mask;
    mask = (32'd1 << bank_bits) - 32'd1;
    return wa & mask;
  endfunction

endpackage

// File: rtl/instr_ram_bank.sv
// Single-port RAM bank with per-byte write enables and a registered read port.
module instr_ram_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned ROW_W      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ROW_W-1:0]        addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // One access per cycle: byte-masked write, or read captured into rdata_q.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_ram_banked_ctrl.sv
// Banked instruction-RAM controller: post-reset scrub, req/gnt/rvalid
// handshake, write protect with error response.
module instr_ram_banked_ctrl
  import instr_ram_pkg::*;
#(
  parameter int unsigned           RAM_SIZE   = 32768,
  parameter int unsigned           NUM_BANKS  = 4,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter logic [DATA_WIDTH-1:0] INIT_WORD  = DATA_WIDTH'(INIT_WORD_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    wp_en_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    init_busy_o
);

  localparam int unsigned WPB    = RAM_SIZE / 4 / NUM_BANKS;
  localparam int unsigned ROW_W  = $clog2(WPB);
  localparam int unsigned BANK_W = $clog2(NUM_BANKS);
  localparam int unsigned WA_W   = ADDR_WIDTH - 2;
  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(WPB - 1);

  state_e             state_q;
  logic [ROW_W-1:0]   cnt_q;
  logic               init_busy_q;

  logic [WA_W-1:0]    wa_c;
  logic [BANK_W-1:0]  bank_idx_c;
  logic [ROW_W-1:0]   row_c;
  logic               scrub_c;
  logic               gnt_c;
  logic               xfer_c;
  logic               wr_drop_c;
  logic               unused_addr_lsb;

  logic [NUM_BANKS-1:0]  bank_en_c;
  logic                  bank_we_c;
  logic [BE_W-1:0]       bank_be_c;
  logic [ROW_W-1:0]      bank_addr_c;
  logic [DATA_WIDTH-1:0] bank_wdata_c;
  logic [DATA_WIDTH-1:0] bank_rdata_c [NUM_BANKS];
  logic [DATA_WIDTH-1:0] rdata_mux_c;

  logic                  rvalid_d, rvalid_q;
  logic                  err_d, err_q;
  logic                  rd_d, rd_q;
  logic [BANK_W-1:0]     bank_d, bank_q;
  logic [DATA_WIDTH-1:0] rdata_hold_d, rdata_hold_q;

  // Address decode: word-interleaved banks, byte offset bits are don't-care.
  assign wa_c            = addr_i[ADDR_WIDTH-1:2];
  assign bank_idx_c      = BANK_W'(bank_sel(32'(wa_c), BANK_W));
  assign row_c           = wa_c[WA_W-1:BANK_W];
  assign unused_addr_lsb = ^addr_i[1:0];

  // Grant follows the request once scrubbing is done.
  assign scrub_c   = (state_q == INIT);
  assign gnt_c     = (state_q == READY) & req_i;
  assign xfer_c    = req_i & gnt_c;
  assign wr_drop_c = we_i & wp_en_i;
  assign gnt_o     = gnt_c;

  // Scrub sequencer: sweep every row of all banks once, then serve requests.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + ROW_W'(1);
          if (cnt_q == LAST_ROW) begin
            state_q     <= READY;
            init_busy_q <= 1'b0;
          end
        end
        READY: begin
          state_q <= READY;
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

  // Bank port steering: scrub writes all banks in parallel, otherwise only the addressed bank.
  always_comb begin
    bank_we_c    = scrub_c | we_i;
    bank_be_c    = scrub_c ? {BE_W{1'b1}} : be_i;
    bank_addr_c  = scrub_c ? cnt_q : row_c;
    bank_wdata_c = scrub_c ? INIT_WORD : wdata_i;
    bank_en_c    = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_en_c[b] = scrub_c
                   | (xfer_c & (bank_idx_c == BANK_W'(b)) & ~wr_drop_c);
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    instr_ram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (WPB),
      .ROW_W      (ROW_W)
    ) u_bank (
      .clk     (clk),
      .en_i    (bank_en_c[g]),
      .we_i    (bank_we_c),
      .be_i    (bank_be_c),
      .addr_i  (bank_addr_c),
      .wdata_i (bank_wdata_c),
      .rdata_o (bank_rdata_c[g])
    );
  end

  // Response next-state: one response per accepted request; read data held between reads.
  always_comb begin
    rdata_mux_c  = bank_rdata_c[bank_q];
    rvalid_d     = xfer_c;
    err_d        = xfer_c & wr_drop_c;
    rd_d         = xfer_c & ~we_i;
    bank_d       = xfer_c ? bank_idx_c : bank_q;
    rdata_hold_d = rd_q ? rdata_mux_c : rdata_hold_q;
  end

  // Response pipeline registers; reset drops any response still in flight.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      rd_q         <= 1'b0;
      bank_q       <= '0;
      rdata_hold_q <= '0;
    end else begin
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      rd_q         <= rd_d;
      bank_q       <= bank_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign rdata_o     = rd_q ? rdata_mux_c : rdata_hold_q;
  assign init_busy_o = init_busy_q;

endmodule

// File: tb/tb_instr_ram_banked_ctrl.sv
// Self-checking bench for instr_ram_banked_ctrl (default parameters).
module tb_instr_ram_banked_ctrl;

  localparam int unsigned WPB   = 2048;
  localparam int unsigned WORDS = 8192;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_i;
  logic        req_i;
  logic        gnt_o;
  logic [14:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        wp_en_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        init_busy_o;

  int          tests_run = 0;
  int          fails     = 0;
  int          cyc       = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mem_m [WORDS];
  logic [31:0] last_rd_m;

  instr_ram_banked_ctrl dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .wp_en_i     (wp_en_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .init_busy_o (init_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: each scoreboard entry is due on exactly one negedge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      tests_run++;
      fails++;
      $display("FAIL rsp_missing: due cyc %0d, now cyc %0d", sb_q[0].cyc, cyc);
      mon_e = sb_q.pop_front();
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      mon_e = sb_q.pop_front();
      tests_run++;
      if (rvalid_o !== 1'b1) begin
        fails++;
        $display("FAIL rsp_rvalid: got %b want 1 (cyc %0d)", rvalid_o, cyc);
      end
      tests_run++;
      if (rdata_o !== mon_e.rdata) begin
        fails++;
        $display("FAIL rsp_rdata: got %h want %h (cyc %0d)", rdata_o, mon_e.rdata, cyc);
      end
      tests_run++;
      if (err_o !== mon_e.err) begin
        fails++;
        $display("FAIL rsp_err: got %b want %b (cyc %0d)", err_o, mon_e.err, cyc);
      end
    end else if (rvalid_o === 1'b1) begin
      tests_run++;
      fails++;
      $display("FAIL rsp_unexpected: rvalid_o=1 with nothing pending (cyc %0d)", cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < int'(WORDS); i++) mem_m[i] = NOP;
    last_rd_m = 32'h0;
  endtask

  // Drive one request at a negedge; expects an immediate grant and queues the response.
  task automatic do_req(input logic we, input logic [14:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic wp);
    exp_t        e;
    logic [12:0] wa;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    be_i    = be;
    wdata_i = wdata;
    wp_en_i = wp;
    #1;
    tests_run++;
    if (gnt_o !== 1'b1) begin
      fails++;
      $display("FAIL gnt: addr %h got %b want 1", addr, gnt_o);
    end
    wa = addr[14:2];
    if (we) begin
      if (!wp) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem_m[wa][b*8 +: 8] = wdata[b*8 +: 8];
        end
      end
      e.rdata = last_rd_m;
      e.err   = wp;
    end else begin
      e.rdata   = mem_m[wa];
      e.err     = 1'b0;
      last_rd_m = mem_m[wa];
    end
    e.cyc = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_i   = 1'b0;
    we_i    = 1'b0;
    wp_en_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    idle(3);
    tests_run++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d responses outstanding, want 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Hold reset for n cycles (n >= 2), then release at a negedge.
  task automatic apply_reset(input int n);
    rst_i = 1'b1;
    req_i = 1'b0;
    repeat (n) @(negedge clk);
    sb_q.delete();
    model_reset();
    rst_i = 1'b0;
  endtask

  // From reset release: count busy cycles while holding a request that must not be granted.
  task automatic wait_init(input string name);
    int n;
    int gnt_bad;
    n       = 0;
    gnt_bad = 0;
    req_i   = 1'b1;
    we_i    = 1'b0;
    addr_i  = 15'h0;
    while (init_busy_o === 1'b1 && n < 5000) begin
      #1;
      if (gnt_o !== 1'b0) gnt_bad++;
      n++;
      @(negedge clk);
    end
    req_i = 1'b0;
    tests_run++;
    if (n != int'(WPB)) begin
      fails++;
      $display("FAIL %s_busy_len: got %0d cycles want %0d", name, n, WPB);
    end
    tests_run++;
    if (gnt_bad != 0) begin
      fails++;
      $display("FAIL %s_gnt_in_init: got %0d grants want 0", name, gnt_bad);
    end
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    req_i   = 1'b1;
    we_i    = 1'b0;
    addr_i  = 15'h0;
    be_i    = 4'h0;
    wdata_i = 32'h0;
    wp_en_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (init_busy_o !== 1'b1) begin fails++; $display("FAIL rst_init_busy: got %b want 1", init_busy_o); end
    tests_run++;
    if (gnt_o !== 1'b0) begin fails++; $display("FAIL rst_gnt: got %b want 0", gnt_o); end
    tests_run++;
    if (rvalid_o !== 1'b0) begin fails++; $display("FAIL rst_rvalid: got %b want 0", rvalid_o); end
    tests_run++;
    if (rdata_o !== 32'h0) begin fails++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
    tests_run++;
    if (err_o !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err_o); end
    @(negedge clk);
    apply_reset(2);
    wait_init("reset");
  endtask

  task automatic test_init_reads();
    do_req(1'b0, 15'h0000, 4'h0, 32'h0, 1'b0);
    do_req(1'b0, 15'h7FFC, 4'h0, 32'h0, 1'b0);
    do_req(1'b0, 15'h1234, 4'h0, 32'h0, 1'b0);
    drain("init_reads");
  endtask

  task automatic test_write_read();
    do_req(1'b1, 15'h0100, 4'hF, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 15'h0100, 4'h0, 32'h0, 1'b0);
    drain("write_read");
  endtask

  task automatic test_byte_enables();
    do_req(1'b1, 15'h0104, 4'b0101, 32'hAABBCCDD, 1'b0);
    do_req(1'b0, 15'h0104, 4'h0, 32'h0, 1'b0);
    do_req(1'b1, 15'h0108, 4'h0, 32'h55667788, 1'b0);
    do_req(1'b0, 15'h0108, 4'h0, 32'h0, 1'b0);
    drain("byte_enables");
    tests_run++;
    if (mem_m[15'h0104 >> 2] !== 32'h00BB00DD) begin
      fails++;
      $display("FAIL be_model: got %h want 00bb00dd", mem_m[15'h0104 >> 2]);
    end
  endtask

  task automatic test_write_protect();
    do_req(1'b1, 15'h0200, 4'hF, 32'hFFFFFFFF, 1'b1);
    do_req(1'b0, 15'h0200, 4'h0, 32'h0, 1'b0);
    drain("write_protect");
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals[0] = 32'h11111111;
    vals[1] = 32'h22222222;
    vals[2] = 32'h33333333;
    vals[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) do_req(1'b1, 15'(i * 4), 4'hF, vals[i], 1'b0);
    for (int i = 0; i < 4; i++) do_req(1'b0, 15'(i * 4), 4'h0, 32'h0, 1'b0);
    drain("back_to_back");
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        do_req(1'($urandom_range(0, 1)),
               15'(32'h400 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3)),
               4'($urandom_range(0, 15)),
               $urandom,
               1'($urandom_range(0, 3) == 0));
      end
    end
    drain("random");
  endtask

  task automatic test_reset_mid_scrub();
    do_req(1'b1, 15'h0300, 4'hF, 32'h12345678, 1'b0);
    // Read granted in the same cycle reset is asserted: its response must vanish.
    rst_i  = 1'b1;
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 15'h0300;
    @(negedge clk);
    req_i = 1'b0;
    tests_run++;
    if (rvalid_o !== 1'b0) begin fails++; $display("FAIL stale_rvalid: got %b want 0", rvalid_o); end
    apply_reset(2);
    idle(100);
    tests_run++;
    if (init_busy_o !== 1'b1) begin fails++; $display("FAIL mid_scrub_busy: got %b want 1", init_busy_o); end
    apply_reset(3);
    wait_init("rescrub");
    do_req(1'b0, 15'h0300, 4'h0, 32'h0, 1'b0);
    drain("reset_mid_scrub");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init_reads();
    test_write_read();
    test_byte_enables();
    test_write_protect();
    test_back_to_back();
    test_random();
    test_reset_mid_scrub();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
